// File: rtl/axi_llc_evict_line_buf.sv
// axi_llc_evict_line_buf: buffers one evicted cache line, then emits it as one AXI AW burst plus BlockSize W beats
module axi_llc_evict_line_buf #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int BlockSize = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   desc_addr_i,
  input  logic                   desc_valid_i,
  output logic                   desc_ready_o,
  input  logic [DataWidth-1:0]   way_data_i,
  input  logic                   way_valid_i,
  output logic                   way_ready_o,
  output logic [AddrWidth-1:0]   aw_addr_o,
  output logic [7:0]             aw_len_o,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [DataWidth-1:0]   w_data_o,
  output logic [DataWidth/8-1:0] w_strb_o,
  output logic                   w_last_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  output logic                   busy_o
);
  localparam int CW = $clog2(BlockSize);
  localparam logic [CW-1:0] LAST = CW'(BlockSize - 1);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] fill_cnt, drain_cnt;
  logic aw_done, w_done;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] line_q [BlockSize];
  logic desc_hs, way_hs, aw_hs, w_hs, fill_end, drain_end;
  assign desc_ready_o = state_q == IDLE;
  assign way_ready_o  = state_q == FILL;
  assign busy_o       = state_q != IDLE;
  assign aw_valid_o   = state_q == DRAIN && !aw_done;
  assign w_valid_o    = state_q == DRAIN && !w_done;
  assign w_last_o     = w_valid_o && drain_cnt == LAST;
  assign w_data_o     = w_valid_o ? line_q[drain_cnt] : '0;
  assign w_strb_o     = '1;
  assign aw_addr_o    = addr_q;
  assign aw_len_o     = 8'(BlockSize - 1);
  assign desc_hs      = desc_valid_i && desc_ready_o;
  assign way_hs       = way_valid_i && way_ready_o;
  assign aw_hs        = aw_valid_o && aw_ready_i;
  assign w_hs         = w_valid_o && w_ready_i;
  assign fill_end     = way_hs && fill_cnt == LAST;
  // W may complete before AW (or vice versa); leave only once both sides are done
  assign drain_end    = state_q == DRAIN && (w_done || (w_hs && w_last_o)) && (aw_done || aw_hs);
  always_comb begin
    state_d = desc_hs ? FILL : fill_end ? DRAIN : drain_end ? IDLE : state_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      fill_cnt  <= '0;
      drain_cnt <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (desc_hs) begin
        addr_q   <= desc_addr_i;
        fill_cnt <= '0;
      end
      if (way_hs) fill_cnt <= fill_end ? '0 : fill_cnt + CW'(1);
      if (fill_end) begin
        drain_cnt <= '0;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) begin
        drain_cnt <= w_last_o ? drain_cnt : drain_cnt + CW'(1);
        w_done    <= w_last_o;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (way_hs) line_q[fill_cnt] <= way_data_i;
  end
endmodule
